// File: rtl/voice_scheduler_pkg.sv
// Shared types and sizes for the voice scheduler.
// Holds widths, voice count and the controller state enum.
package voice_sched_pkg;

  localparam int NUM_VOICES = 3;
  localparam int NOTE_W     = 6;
  localparam int DUR_W      = 6;
  localparam int META_W     = 3;
  localparam int VIDX_W     = $clog2(NUM_VOICES);

  typedef enum logic [1:0] {
    S_WAIT = 2'd0,
    S_HOLD = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  // Chord notes do not hold the song reader.
  function automatic logic is_chord(
    input logic [META_W-1:0] meta
  );
    return meta[0];
  endfunction

endpackage

// File: rtl/voice_scheduler_if.sv
// Song-reader <-> scheduler bundle.
// master = song reader side, slave = scheduler side.
interface voice_scheduler_if
  import voice_sched_pkg::*;
(
  input logic clk
);

  logic                  play;
  logic                  beat;
  logic                  new_note;
  logic [NOTE_W-1:0]     note;
  logic [DUR_W-1:0]      duration;
  logic [META_W-1:0]     metadata;
  logic                  note_done;
  logic [NUM_VOICES-1:0] voice_load;
  logic [NOTE_W-1:0]     voice0_note;
  logic [NOTE_W-1:0]     voice1_note;
  logic [NOTE_W-1:0]     voice2_note;
  logic [NUM_VOICES-1:0] voice_active;
  logic                  steal;
  logic                  drop;

  modport master (
    input  clk,
    output play, beat, new_note,
    output note, duration, metadata,
    input  note_done, voice_load,
    input  voice0_note, voice1_note,
    input  voice2_note, voice_active,
    input  steal, drop
  );

  modport slave (
    input  clk,
    input  play, beat, new_note,
    input  note, duration, metadata,
    output note_done, voice_load,
    output voice0_note, voice1_note,
    output voice2_note, voice_active,
    output steal, drop
  );

endinterface

// File: rtl/voice_scheduler_voice_counter.sv
// One voice: pitch register, remaining-beat counter, active flag.
// Ports: clk, reset(async low), play_i, beat_i, load_i, note_i, dur_i -> active_o, count_o, note_o.
module voice_counter
  import voice_sched_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              play_i,
  input  logic              beat_i,
  input  logic              load_i,
  input  logic [NOTE_W-1:0] note_i,
  input  logic [DUR_W-1:0]  dur_i,
  output logic              active_o,
  output logic [DUR_W-1:0]  count_o,
  output logic [NOTE_W-1:0] note_o
);

  logic [DUR_W-1:0]  cnt_q, cnt_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              act_q, act_d;

  // A load in the same cycle as a beat wins.
  always_comb begin
    cnt_d  = cnt_q;
    note_d = note_q;
    if (load_i) begin
      cnt_d  = dur_i;
      note_d = note_i;
    end else if (play_i && beat_i &&
                 cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
    act_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      note_q <= '0;
      act_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      note_q <= note_d;
      act_q  <= act_d;
    end
  end

  assign active_o = act_q;
  assign count_o  = cnt_q;
  assign note_o   = note_q;

endmodule

// File: rtl/voice_scheduler.sv
// Note scheduler: allocates incoming notes to voices and gates the song reader.
// Ports: clk, reset(async low), play, beat, new_note, note, duration, metadata ->
//   note_done, voice_load, voiceN_note, voice_active, steal, drop.
// Option: VOICE_STEAL_EN defined -> steal the voice with least remaining time when full.
module voice_scheduler
  import voice_sched_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play,
  input  logic                  beat,
  input  logic                  new_note,
  input  logic [NOTE_W-1:0]     note,
  input  logic [DUR_W-1:0]      duration,
  input  logic [META_W-1:0]     metadata,
  output logic                  note_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice0_note,
  output logic [NOTE_W-1:0]     voice1_note,
  output logic [NOTE_W-1:0]     voice2_note,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  steal,
  output logic                  drop
);

  logic [NUM_VOICES-1:0]             act;
  logic [NUM_VOICES-1:0]             load_d;
  logic [NUM_VOICES-1:0]             load_q;
  logic [NUM_VOICES-1:0][DUR_W-1:0]  cnt;
  logic [NUM_VOICES-1:0][NOTE_W-1:0] vnote;

  state_e            state_q;
  logic [DUR_W-1:0]  gate_q;
  logic              steal_d, steal_q;
  logic              drop_d, drop_q;
  logic              accept, want;
  logic              free_ok;
  logic [VIDX_W-1:0] free_idx;
  logic              unused_meta;

  assign unused_meta = ^metadata[META_W-1:1];

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    voice_counter u_voice (
      .clk      (clk),
      .reset    (reset),
      .play_i   (play),
      .beat_i   (beat),
      .load_i   (load_d[i]),
      .note_i   (note),
      .dur_i    (duration),
      .active_o (act[i]),
      .count_o  (cnt[i]),
      .note_o   (vnote[i])
    );
  end

  assign accept = play && new_note &&
                  (state_q == S_WAIT);
  assign want   = accept &&
                  (note != '0) &&
                  (duration != '0);

  // Lowest-index idle voice.
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = NUM_VOICES-1; i >= 0; i--) begin
      if (!act[i]) begin
        free_ok  = 1'b1;
        free_idx = VIDX_W'(i);
      end
    end
  end

`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0] vic;

  // Least remaining count; strict compare keeps lowest index on ties.
  always_comb begin
    vic = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (cnt[i] < cnt[vic])
        vic = VIDX_W'(i);
    end
  end
`else
  logic unused_cnt;

  assign unused_cnt = ^cnt;
`endif

  always_comb begin
    load_d  = '0;
    steal_d = 1'b0;
    drop_d  = 1'b0;
    if (want) begin
      if (free_ok) begin
        load_d[free_idx] = 1'b1;
      end else begin
`ifdef VOICE_STEAL_EN
        load_d[vic] = 1'b1;
        steal_d     = 1'b1;
`else
        drop_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_WAIT;
      gate_q  <= '0;
      load_q  <= '0;
      steal_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      load_q  <= load_d;
      steal_q <= steal_d;
      drop_q  <= drop_d;
      if (play) begin
        unique case (state_q)
          S_WAIT: begin
            if (new_note) begin
              if (is_chord(metadata) ||
                  duration == '0) begin
                state_q <= S_ACK;
              end else begin
                state_q <= S_HOLD;
                gate_q  <= duration;
              end
            end
          end
          S_HOLD: begin
            if (beat && gate_q != '0) begin
              gate_q <= gate_q - 1'b1;
              if (gate_q == DUR_W'(1))
                state_q <= S_ACK;
            end
          end
          S_ACK: begin
            state_q <= S_WAIT;
          end
          default: begin
            state_q <= S_WAIT;
          end
        endcase
      end
    end
  end

  // While paused the ACK cycle is held and its pulse withheld.
  assign note_done    = (state_q == S_ACK) && play;
  assign voice_load   = load_q;
  assign voice0_note  = vnote[0];
  assign voice1_note  = vnote[1];
  assign voice2_note  = vnote[2];
  assign voice_active = act;
  assign steal        = steal_q;
  assign drop         = drop_q;

endmodule

// File: doc/voice_scheduler.md
VOICE_SCHEDULER -- requirements
Module: voice_scheduler

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 Ports SHALL be, in order:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- play  in  1  1 = advance time; 0 = freeze all counters and state.
- beat  in  1  one-cycle beat pulse.
- new_note  in  1  one-cycle pulse from song reader; note/duration/metadata valid.
- note  in  6  pitch; 0 = rest.
- duration  in  6  length in beats.
- metadata  in  3  bit0 = chord flag (do not wait); bits 2:1 unused.
- note_done  out  1  one-cycle pulse; song reader may fetch next note.
- voice_load  out  3  one-hot pulse; voice i loaded this cycle.
- voice0_note, voice1_note, voice2_note  out  6 each  held pitch per voice.
- voice_active  out  3  bit i = voice i sounding.
- steal  out  1  pulse; an active voice was overwritten.
- drop  out  1  pulse; note discarded, no free voice.

Function
REQ-003 FSM states SHALL be WAIT (idle, expect new_note), HOLD (gate counting), ACK (drive note_done).
REQ-004 new_note in WAIT at cycle N SHALL register inputs; at N+1 the allocated voice's note register, counter (=duration) and voice_active bit SHALL update and voice_load SHALL pulse.
REQ-005 Allocation SHALL pick the lowest-index inactive voice.
REQ-006 note==0 or duration==0 SHALL allocate no voice (no voice_load).
REQ-007 metadata[0]=1 or duration==0: FSM SHALL go WAIT->ACK, note_done pulses at N+1.
REQ-008 Otherwise the gate counter SHALL load duration at N+1, FSM -> HOLD; each beat with play=1 decrements it; on reaching 0 FSM -> ACK, note_done pulses the following cycle, then WAIT.
REQ-009 ACK SHALL last exactly one cycle.
REQ-010 Each voice counter SHALL decrement on beat with play=1; on reaching 0 its voice_active clears in the same update; voiceN_note holds its last value.
REQ-011 Load and beat on the same voice in one cycle: load SHALL win (counter = duration).
REQ-012 play=0 SHALL freeze the FSM and all counters; beats are ignored; a pending note_done is deferred until play=1.
REQ-013 new_note outside WAIT SHALL be ignored without side effects.
REQ-014 Counters SHALL be 6-bit unsigned, never decrementing below 0.

Reset
REQ-015 reset=0 SHALL immediately force FSM=WAIT, all counters=0, voice_active=0, voiceN_note=0, note_done=voice_load=steal=drop=0, including mid-HOLD.
REQ-016 The first new_note SHALL be accepted the first rising edge after reset deasserts.

Configuration
REQ-017 Macro VOICE_STEAL_EN defined: all voices active on allocation SHALL overwrite the voice with smallest remaining count (ties -> lowest index), pulse steal with voice_load.
REQ-018 VOICE_STEAL_EN undefined: the pitch SHALL be discarded, drop pulses at N+1, steal is tied 0; gate/note_done timing is unchanged.

Structure
REQ-019 Package voice_sched_pkg SHALL hold NUM_VOICES=3, NOTE_W=6, DUR_W=6, META_W=3, and the FSM state enum.
REQ-020 Sub-module voice_counter SHALL implement one voice (load, beat-decrement, active flag, note register); instantiated NUM_VOICES times.

Verification
REQ-021 Reset mid-HOLD (duration 8, after 3 beats) -> all outputs 0, FSM WAIT within the same cycle.
REQ-022 new_note note=20 dur=2 meta=0 -> voice_load=001 at N+1, voice0_note=20, note_done exactly one cycle after the 2nd beat, voice_active=000 after it.
REQ-023 Three chord notes (meta=1) 10,14,17 dur=4, then note 22 meta=0 -> voice_load 001,010,100; note_done at N+1 each; fourth note steals (steal=1) with macro, drop=1 without.
REQ-024 note=0 dur=3 -> no voice_load, voice_active unchanged, note_done after 3rd beat.
REQ-025 play=0 during HOLD with 5 beats pulsed -> counters unchanged, no note_done; play=1 resumes count.
REQ-026 beat coincident with voice_load on voice 0 (dur=4) -> counter reads 4, not 3.
